// File: rtl/scp_alert_pkg.sv
// scp_alert_pkg: shared state encodings, alert level codes and light patterns for the alert sequencer
package scp_alert_pkg;
  typedef enum logic [2:0] {
    ST_GREEN    = 3'd0,
    ST_YELLOW   = 3'd1,
    ST_RED      = 3'd2,
    ST_COOLDOWN = 3'd3
  } state_t;
  localparam logic [1:0] LVL_YELLOW = 2'd1;
  localparam logic [1:0] LVL_RED    = 2'd2;
  localparam logic [2:0] LIGHT_G = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_R = 3'b001;
  function automatic logic [2:0] light_of(state_t s);
    return s == ST_GREEN ? LIGHT_G : s == ST_RED ? LIGHT_R : LIGHT_Y;
  endfunction
endpackage

// File: rtl/scp_dwell_timer.sv
// scp_dwell_timer: saturating tick counter with synchronous clear and asynchronous active-low reset
module scp_dwell_timer #(
  parameter int TW = 8
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          clr,
  output logic [TW-1:0] count
);
  // count ticks in the current state, holding at all-ones
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (count != '1) count <= count + 1'b1;
endmodule

// File: rtl/scp_alert_sequencer.sv
// scp_alert_sequencer: one-hot containment light sequencer; SCP_ESC_COUNT_EN adds the esc_count output
module scp_alert_sequencer
  import scp_alert_pkg::*;
#(
  parameter int YELLOW_HOLD = 20,
  parameter int RED_HOLD    = 10,
  parameter int ESC_TIMEOUT = 40,
  parameter int TW          = 8
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          alert_req,
  input  logic [1:0]    alert_lvl,
  input  logic          clear_req,
  input  logic          ack,
  output logic          green,
  output logic          yellow,
  output logic          red,
  output logic [2:0]    state,
  output logic [TW-1:0] timer,
  output logic          clear_pend
`ifdef SCP_ESC_COUNT_EN
  ,
  output logic [7:0]    esc_count
`endif
);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_HOLD - 1);
  localparam logic [TW-1:0] R_LAST = TW'(RED_HOLD - 1);
  localparam logic [TW-1:0] E_LAST = TW'(ESC_TIMEOUT - 1);
  state_t     st, st_nx;
  logic       acked, acked_nx, pend_nx, chg, up_y, up_r, clr;
  logic [2:0] lights;
  assign up_y = alert_req && alert_lvl == LVL_YELLOW;
  assign up_r = alert_req && alert_lvl == LVL_RED;
  assign clr  = clear_req && !alert_req;
  assign chg  = st_nx != st;
  assign state = st;
  assign {green, yellow, red} = lights;
  scp_dwell_timer #(.TW(TW)) u_timer (
    .clock(clock),
    .rst_n(rst_n),
    .clr  (chg),
    .count(timer)
  );
  // next state plus pending-clear and acknowledge flags, both dropped on any state change
  always_comb begin
    st_nx    = ST_GREEN;
    pend_nx  = clear_pend;
    acked_nx = acked;
    case (st)
      ST_GREEN: st_nx = up_r ? ST_RED : up_y ? ST_YELLOW : ST_GREEN;
      ST_YELLOW: begin
        pend_nx  = clear_pend | clr;
        acked_nx = acked | ack;
        st_nx    = up_r ? ST_RED :
                   (timer >= Y_LAST && (clr || clear_pend)) ? ST_GREEN :
                   (!acked && timer == E_LAST) ? ST_RED : ST_YELLOW;
      end
      ST_RED: begin
        pend_nx = clear_pend | clr;
        st_nx   = (timer >= R_LAST && (clr || clear_pend)) ? ST_COOLDOWN : ST_RED;
      end
      ST_COOLDOWN: st_nx = up_r ? ST_RED : up_y ? ST_YELLOW : timer == Y_LAST ? ST_GREEN : ST_COOLDOWN;
      default: st_nx = ST_GREEN;
    endcase
    if (st_nx != st) begin
      pend_nx  = 1'b0;
      acked_nx = 1'b0;
    end
  end
  // state register with lights registered from the next state so they are always one-hot
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      st         <= ST_GREEN;
      clear_pend <= 1'b0;
      acked      <= 1'b0;
      lights     <= LIGHT_G;
    end else begin
      st         <= st_nx;
      clear_pend <= pend_nx;
      acked      <= acked_nx;
      lights     <= light_of(st_nx);
    end
`ifdef SCP_ESC_COUNT_EN
  // count entries into RED, saturating
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) esc_count <= '0;
    else if (chg && st_nx == ST_RED && esc_count != 8'hff) esc_count <= esc_count + 8'd1;
`endif
endmodule

// File: tb/tb_scp_alert_sequencer.sv
// tb_scp_alert_sequencer: randomized bench checking the alert sequencer against a dwell-rule model every cycle
module tb_scp_alert_sequencer;
  localparam int YH = 20, RH = 10, ET = 40, TW = 8;
  logic          clock = 1'b0, rst_n = 1'b0;
  logic          alert_req = 1'b0, clear_req = 1'b0, ack = 1'b0;
  logic [1:0]    alert_lvl = 2'd0;
  logic          green, yellow, red, clear_pend;
  logic [2:0]    state;
  logic [TW-1:0] timer;
`ifdef SCP_ESC_COUNT_EN
  logic [7:0]    esc_count;
`endif
  int checks = 0, errors = 0;
  bit run = 1'b0;
  scp_alert_sequencer #(.YELLOW_HOLD(YH), .RED_HOLD(RH), .ESC_TIMEOUT(ET), .TW(TW)) dut (
    .clock(clock), .rst_n(rst_n), .alert_req(alert_req), .alert_lvl(alert_lvl),
    .clear_req(clear_req), .ack(ack), .green(green), .yellow(yellow), .red(red),
    .state(state), .timer(timer), .clear_pend(clear_pend)
`ifdef SCP_ESC_COUNT_EN
    , .esc_count(esc_count)
`endif
  );
  always #5 clock = ~clock;
  // model: phase 0 green, 1 yellow, 2 red, 3 cooldown; t = ticks already spent in the phase
  typedef struct {int st; int t; bit pend; bit acked; int esc;} mdl_t;
  mdl_t m;
  function automatic mdl_t mnext(mdl_t c, bit a, int lvl, bit cq, bit k);
    mdl_t n = c;
    bit want_r = a && lvl == 2;
    bit want_y = a && lvl == 1;
    bit cl = cq && !a;
    int dwell = c.t + 1;
    int to = c.st;
    if (c.st == 0) to = want_r ? 2 : want_y ? 1 : 0;
    else if (c.st == 1) begin
      n.acked = c.acked | k;
      n.pend = c.pend | cl;
      if (want_r) to = 2;
      else if ((cl || c.pend) && dwell >= YH) to = 0;
      else if (!c.acked && dwell == ET) to = 2;
    end else if (c.st == 2) begin
      n.pend = c.pend | cl;
      if ((cl || c.pend) && dwell >= RH) to = 3;
    end else begin
      if (want_r) to = 2;
      else if (want_y) to = 1;
      else if (dwell == YH) to = 0;
    end
    if (to != c.st) begin
      n.t = 0;
      n.pend = 0;
      n.acked = 0;
      if (to == 2 && c.esc < 255) n.esc = c.esc + 1;
    end else n.t = dwell > 255 ? 255 : dwell;
    n.st = to;
    return n;
  endfunction
  function automatic logic [2:0] exp_lights(int s);
    return s == 0 ? 3'b100 : s == 2 ? 3'b001 : 3'b010;
  endfunction
  always @(posedge clock or negedge rst_n)
    if (!rst_n) m <= '{0, 0, 1'b0, 1'b0, 0};
    else m <= mnext(m, alert_req, int'(alert_lvl), clear_req, ack);
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // every-cycle comparison against the model, away from the rising edge
  always @(negedge clock)
    if (run && rst_n) begin
      chk("lights", int'({green, yellow, red}), int'(exp_lights(m.st)));
      chk("onehot", $countones({green, yellow, red}), 1);
      chk("state", int'(state), m.st);
      chk("timer", int'(timer), m.t);
      chk("clear_pend", int'(clear_pend), int'(m.pend));
`ifdef SCP_ESC_COUNT_EN
      chk("esc_count", int'(esc_count), m.esc);
`endif
    end
  task automatic cyc(input logic a, input logic [1:0] l, input logic c, input logic k);
    alert_req = a;
    alert_lvl = l;
    clear_req = c;
    ack = k;
    @(negedge clock);
  endtask
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clock);
  endtask
  task automatic count_while(input logic [2:0] pat, output int n);
    n = 0;
    while ({green, yellow, red} == pat && n < 300) begin
      n++;
      cyc(0, 0, 0, 0);
    end
  endtask
  initial begin
    int n, last;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("rst_lights", int'({green, yellow, red}), 3'b100);
    chk("rst_state", int'(state), 0);
    chk("rst_timer", int'(timer), 0);
    run = 1'b1;
    @(negedge clock);
    cyc(1, 1, 0, 0);
    count_while(3'b010, n);
    chk("esc_yellow_len", n, 40);
    chk("esc_red", int'(red), 1);
`ifdef SCP_ESC_COUNT_EN
    chk("esc_count_one", int'(esc_count), 1);
`endif
    pulse_reset();
    cyc(1, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("pend_set", int'(clear_pend), 1);
    last = -1;
    n = 0;
    while (yellow && n < 100) begin
      last = int'(timer);
      n++;
      cyc(0, 0, 0, 0);
    end
    chk("pend_last_timer", last, 19);
    chk("pend_green", int'({green, yellow, red}), 3'b100);
    pulse_reset();
    cyc(1, 2, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    count_while(3'b001, n);
    chk("red_len", n + 2, 10);
    count_while(3'b010, n);
    chk("cool_len", n, 20);
    chk("cool_green", int'({green, yellow, red}), 3'b100);
    pulse_reset();
    cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 0);
    n = 0;
    while (state != 3'd3 && n < 50) begin
      n++;
      cyc(0, 0, 0, 0);
    end
    chk("reach_cooldown", int'(state), 3);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 2, 1, 0);
    chk("cool_alert_lights", int'({green, yellow, red}), 3'b001);
    chk("cool_alert_timer", int'(timer), 0);
    chk("cool_alert_pend", int'(clear_pend), 0);
    repeat (300) cyc(0, 0, 0, 0);
    chk("timer_sat", int'(timer), 255);
    pulse_reset();
    cyc(1, 0, 0, 0);
    chk("lvl0_ignored", int'({green, yellow, red}), 3'b100);
    cyc(1, 3, 0, 0);
    chk("lvl3_ignored", int'(state), 0);
    cyc(1, 2, 0, 0);
    cyc(1, 1, 0, 0);
    chk("red_ignores_lvl1", int'(red), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_lights", int'({green, yellow, red}), 3'b100);
    chk("async_state", int'(state), 0);
    chk("async_timer", int'(timer), 0);
    rst_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 20000; i++) begin
      cyc($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0,
          $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2999) == 0) pulse_reset();
    end
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
